// File: rtl/dmem_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_unit_if : CPU / front-panel bus bundle for the i281 data memory      |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
interface dmem_unit_if #(
  parameter int ADDR_W = 4
);
  logic              run;
  logic              c24;
  logic [ADDR_W-1:0] dmem_addr;
  logic [7:0]        dmem_wdata;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic [7:0]        datamemory;
  logic              ready;
  logic              wr_ack;

  modport master (
    output run, c24, dmem_addr, dmem_wdata, load_en, load_addr, load_data,
    input  datamemory, ready, wr_ack
  );

  modport slave (
    input  run, c24, dmem_addr, dmem_wdata, load_en, load_addr, load_data,
    output datamemory, ready, wr_ack
  );
endinterface
`default_nettype wire

// File: rtl/dmem_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_unit : 16x8 i281 data memory with post-reset clear sweep             |
// | Optional macro DMEM_WRITE_FORWARD_EN forwards CPU store data to the read. |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module dmem_unit #(
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  INIT_VAL = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  dmem_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_wr_ack;
  logic              w_ack_nxt;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;
  logic [7:0]        r_mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_CLEAR;
      r_cnt    <= '0;
      r_wr_ack <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_wr_ack <= w_ack_nxt;
    end
  end

  // The run-based lockouts make CPU and load acceptance mutually exclusive.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_cnt;
    w_wdata     = INIT_VAL;
    case (r_state)
      S_CLEAR: begin
        w_we      = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == C_LAST) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (bus.run && bus.c24) begin
          w_we      = 1'b1;
          w_waddr   = bus.dmem_addr;
          w_wdata   = bus.dmem_wdata;
          w_ack_nxt = 1'b1;
        end else if (!bus.run && bus.load_en) begin
          w_we      = 1'b1;
          w_waddr   = bus.load_addr;
          w_wdata   = bus.load_data;
          w_ack_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Array has no reset; writes are held off while reset is asserted.
  always_ff @(posedge clock) begin
    if (w_we && reset) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_comb begin
    bus.datamemory = 8'h00;
    if (r_state == S_READY) begin
      bus.datamemory = r_mem[bus.dmem_addr];
`ifdef DMEM_WRITE_FORWARD_EN
      if (bus.run && bus.c24) begin
        bus.datamemory = bus.dmem_wdata;
      end
`endif
    end
  end

  assign bus.ready  = (r_state == S_READY);
  assign bus.wr_ack = r_wr_ack;

endmodule
`default_nettype wire
